// File: rtl/aes_decrypt_if.sv
// aes_decrypt_if: request/result bundle for the AES-128 decryption core.
//   start_decryption  request, sampled only while the core is idle
//   ciphertext_in     128-bit ciphertext, bit 127 = byte 0 (FIPS-197 order)
//   key_in            128-bit cipher key, same byte order
//   plaintext_out     registered result, held until the next completion/reset
//   decryption_done   one-cycle pulse when plaintext_out is updated
//   busy              high while a block is in flight
// master = requester side, slave = core side.
interface aes_decrypt_if;
  logic         start_decryption;
  logic [127:0] ciphertext_in;
  logic [127:0] key_in;
  logic [127:0] plaintext_out;
  logic         decryption_done;
  logic         busy;

  modport master (
    output start_decryption, ciphertext_in, key_in,
    input  plaintext_out, decryption_done, busy
  );

  modport slave (
    input  start_decryption, ciphertext_in, key_in,
    output plaintext_out, decryption_done, busy
  );
endinterface

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryption core.
// Accepts a ciphertext and cipher key, runs ten cycles of forward key
// expansion to reach round key 10, then ten inverse rounds (one per cycle)
// while walking the key schedule backwards, so no round keys are stored.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous reset, ACTIVE HIGH despite its name
//   bus    aes_decrypt_if.slave (start/ciphertext/key in, plaintext/done/busy out)
// Latency is 20 cycles from the accept edge to decryption_done.
module aes_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  aes_decrypt_if.slave bus
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_EXP = 4'd10;
  localparam logic [CNT_W-1:0] FIRST_RND = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    ROUND  = 2'd2
  } fsm_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [255:0][7:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same layout.
  localparam logic [255:0][7:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Tables are stored with entry 0 at the top index, hence the inversion.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[~b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_T[~b];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gmul_c(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? b2 : 8'h00) ^
           (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gmul_c(a0, 4'he) ^ gmul_c(a1, 4'hb) ^ gmul_c(a2, 4'hd) ^ gmul_c(a3, 4'h9),
      gmul_c(a0, 4'h9) ^ gmul_c(a1, 4'he) ^ gmul_c(a2, 4'hb) ^ gmul_c(a3, 4'hd),
      gmul_c(a0, 4'hd) ^ gmul_c(a1, 4'h9) ^ gmul_c(a2, 4'he) ^ gmul_c(a3, 4'hb),
      gmul_c(a0, 4'hb) ^ gmul_c(a1, 4'hd) ^ gmul_c(a2, 4'h9) ^ gmul_c(a3, 4'he)
    };
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [BLK_W-1:0] plaintext_q, plaintext_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Key schedule: one set of four S-boxes serves both directions.
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] g_in, g_word;
  logic [WORD_W-1:0] f0, f1, f2, f3;
  logic [7:0]        rc;
  logic [BLK_W-1:0]  key_fwd, key_prev;

  always_comb begin
    {w0, w1, w2, w3} = key_q;
    if (fsm_q == ROUND) begin
      // Going backwards, the old w3 is recovered as w2 ^ w3 of the newer key.
      g_in = w2 ^ w3;
      rc   = rcon(4'(rcnt_q + 4'd1));
    end else begin
      g_in = w3;
      rc   = rcon(rcnt_q);
    end
    g_word = {sbox(g_in[23:16]), sbox(g_in[15:8]), sbox(g_in[7:0]), sbox(g_in[31:24])} ^
             {rc, 24'h000000};
    f0 = w0 ^ g_word;
    f1 = f0 ^ w1;
    f2 = f1 ^ w2;
    f3 = f2 ^ w3;
    key_fwd  = {f0, f1, f2, f3};
    key_prev = {w0 ^ g_word, w0 ^ w1, w1 ^ w2, w2 ^ w3};
  end

  // Inverse round: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns.
  logic [BLK_W-1:0] isb_blk, t_blk, imc_blk;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r: output column c takes input column c-r.
      localparam int unsigned DST = 4 * c + r;
      localparam int unsigned SRC = 4 * ((c + 4 - r) % 4) + r;
      assign isb_blk[BLK_W-1-8*DST -: 8] = inv_sbox(state_q[BLK_W-1-8*SRC -: 8]);
    end
    localparam int unsigned HI = BLK_W - 1 - WORD_W * c;
    assign imc_blk[HI -: WORD_W] = inv_mix_col(t_blk[HI -: WORD_W]);
  end

  assign t_blk = isb_blk ^ key_prev;

  // Next-state and datapath control.
  always_comb begin
    fsm_d       = fsm_q;
    rcnt_d      = rcnt_q;
    ct_d        = ct_q;
    key_d       = key_q;
    state_d     = state_q;
    plaintext_d = plaintext_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    case (fsm_q)
      IDLE: begin
        if (bus.start_decryption) begin
          ct_d   = bus.ciphertext_in;
          key_d  = bus.key_in;
          rcnt_d = 4'd1;
          busy_d = 1'b1;
          fsm_d  = EXPAND;
        end
      end
      EXPAND: begin
        key_d  = key_fwd;
        rcnt_d = 4'(rcnt_q + 4'd1);
        if (rcnt_q == LAST_EXP) begin
          // Initial AddRoundKey with round key 10.
          state_d = ct_q ^ key_fwd;
          rcnt_d  = FIRST_RND;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rcnt_q != '0) begin
          state_d = imc_blk;
          key_d   = key_prev;
          rcnt_d  = 4'(rcnt_q - 4'd1);
        end else begin
          plaintext_d = t_blk;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fsm_q       <= IDLE;
      rcnt_q      <= '0;
      ct_q        <= '0;
      key_q       <= '0;
      state_q     <= '0;
      plaintext_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      rcnt_q      <= rcnt_d;
      ct_q        <= ct_d;
      key_q       <= key_d;
      state_q     <= state_d;
      plaintext_q <= plaintext_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.plaintext_out   = plaintext_q;
  assign bus.decryption_done = done_q;
  assign bus.busy            = busy_q;

endmodule
